// File: rtl/index_mask_decoder.sv
// index_mask_decoder
//   Rebuilds an N-bit request/grant mask (N = 2**IDX_W) from a serialized
//   stream of encoded indices. Each accepted beat sets bit in_idx of an
//   accumulator. On the frame's last beat, the mask, a duplicate flag and a
//   saturating beat count are loaded into output registers and held until
//   the downstream side takes them.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     upstream beat handshake
//   in_idx, in_last       encoded index of the beat, last-beat-of-frame flag
//   out_valid/out_ready   result handshake (registered)
//   out_mask              reconstructed mask
//   out_dup               some index repeated within the frame
//   out_count             accepted beats in the frame, saturating

// Per-bit slice: one accumulator bit and one output bit.
module index_mask_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic hit,      // this lane is the decoded index of the current beat
  input  logic acc_upd,  // accepted non-last beat
  input  logic acc_clr,  // accepted last beat: accumulator restarts
  input  logic out_ld,   // accepted last beat: capture result
  output logic acc_bit,
  output logic out_bit
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_bit <= 1'b0;
      out_bit <= 1'b0;
    end else begin
      if (acc_clr)             acc_bit <= 1'b0;
      else if (acc_upd && hit) acc_bit <= 1'b1;
      // the last beat's own index is folded into the captured result
      if (out_ld)              out_bit <= acc_bit | hit;
    end
  end
endmodule

module index_mask_decoder #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<IDX_W)-1:0] out_mask,
  output logic                  out_dup,
  output logic [CNT_W-1:0]      out_count
);
  localparam int N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nxt;

  logic [N-1:0]     onehot;
  logic [N-1:0]     acc_mask;
  logic             acc_dup;
  logic [CNT_W-1:0] acc_count;
  logic [CNT_W-1:0] count_nxt;
  logic             accept, upd, fin, dup_hit;

  // in_ready depends on state only; forced low while reset is asserted.
  assign in_ready  = rst_n && (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign accept = in_valid && in_ready;
  assign upd    = accept && !in_last;
  assign fin    = accept && in_last;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign onehot[i] = (in_idx == IDX_W'(i));
    index_mask_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit     (onehot[i]),
      .acc_upd (upd),
      .acc_clr (fin),
      .out_ld  (fin),
      .acc_bit (acc_mask[i]),
      .out_bit (out_mask[i])
    );
  end

  // Repeat detected when the incoming index is already in the accumulator.
  assign dup_hit   = |(acc_mask & onehot);
  assign count_nxt = (acc_count == CNT_MAX) ? acc_count : acc_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_dup   <= 1'b0;
      acc_count <= '0;
      out_dup   <= 1'b0;
      out_count <= '0;
    end else if (fin) begin
      acc_dup   <= 1'b0;
      acc_count <= '0;
      out_dup   <= acc_dup | dup_hit;
      out_count <= count_nxt;
    end else if (upd) begin
      acc_dup   <= acc_dup | dup_hit;
      acc_count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (fin)       state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = ACCUM;
      default:              state_nxt = ACCUM;
    endcase
  end
endmodule

// File: tb/tb_index_mask_decoder.sv
module tb_index_mask_decoder;
  typedef struct packed {
    logic [7:0] mask;
    logic       dup;
    logic [3:0] count;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_mask;
  logic       out_dup;
  logic [3:0] out_count;

  int   vectors = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  index_mask_decoder #(.IDX_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_dup(out_dup), .out_count(out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the result is presented it must equal the queue head
  // (so it also stays stable under backpressure); pop when it is consumed.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_mask",  32'(out_mask),  32'(exp_q[0].mask));
          check("out_dup",   32'(out_dup),   32'(exp_q[0].dup));
          check("out_count", 32'(out_count), 32'(exp_q[0].count));
          check("in_ready_in_hold", 32'(in_ready), 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one beat and wait until it is accepted at a rising edge.
  task automatic beat(input logic [2:0] idx, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_idx = idx; in_last = last;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input logic [7:0] m, input logic d, input logic [3:0] c);
    res_t r;
    r.mask = m; r.dup = d; r.count = c;
    exp_q.push_back(r);
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    #2;
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    check("out_valid_during_reset", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_out_mask",  32'(out_mask), 32'h00);
    check("reset_out_dup",   32'(out_dup), 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_in_ready",  32'(in_ready), 32'd1);

    // frame 0,3,7: beat() returns at negedge after edge k (monitor sees valid)
    push(8'h89, 1'b0, 4'd3);
    beat(3'd0, 1'b0); beat(3'd3, 1'b0);
    // last beat: beat task ends on negedge after edge k
    beat(3'd7, 1'b1);
    #1;
    check("frame1_out_valid_after_last", 32'(out_valid), 32'd1);
    @(negedge clk); #3;
    check("frame1_out_valid_after_consume", 32'(out_valid), 32'd0);
    check("frame1_in_ready_after_consume", 32'(in_ready), 32'd1);

    // single beat
    push(8'h20, 1'b0, 4'd1);
    beat(3'd5, 1'b1);

    // repeated index on the last beat
    push(8'h14, 1'b1, 4'd3);
    beat(3'd2, 1'b0); beat(3'd4, 1'b0); beat(3'd2, 1'b1);

    // backpressure: result held, next beat waits on in_ready
    @(negedge clk);
    out_ready = 1'b0;
    push(8'h02, 1'b0, 4'd1);
    beat(3'd1, 1'b1);
    in_valid = 1'b1; in_idx = 3'd6; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    push(8'h40, 1'b0, 4'd1);
    out_ready = 1'b1;
    beat(3'd6, 1'b1);

    // saturation: 20 beats cycling 0..7
    push(8'hFF, 1'b1, 4'd15);
    for (int i = 0; i < 20; i++) beat(3'(i % 8), i == 19);

    // reset mid-frame discards the partial frame
    beat(3'd0, 1'b0); beat(3'd1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("post_reset_out_valid", 32'(out_valid), 32'd0);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    push(8'h10, 1'b0, 4'd1);
    beat(3'd4, 1'b1);

    // drain
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("results_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
